// File: rtl/mmio_uart_tx.sv
// Store-bus snooping UART transmitter: bytes stored to TX_ADDR are queued in a
// FIFO and shifted out as 8N1 frames on tx without ever stalling the core.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_FFF0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MemWrite,
  input  logic [31:0]                   DataAddr,
  input  logic [31:0]                   WriteData,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic            push_s, pop_s, full_s, accept_s, last_s, nonempty_s;
  logic            unused_s;

  assign unused_s = &{1'b0, WriteData[31:8]};

  // Transmit FSM next state; a pop happens on leaving IDLE or on the last STOP cycle.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    nonempty_s = (count_q != CW'(0));
    last_s     = (baud_q == BW'(CLKS_PER_BIT - 1));
    case (state_q)
      IDLE: begin
        baud_d = BW'(0);
        if (nonempty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (last_s) begin
          baud_d  = BW'(0);
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (last_s) begin
          baud_d  = BW'(0);
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (last_s) begin
          baud_d = BW'(0);
          if (nonempty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = BW'(0);
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    push_s     = MemWrite && (DataAddr == TX_ADDR);
    full_s     = (count_q == CW'(FIFO_DEPTH));
    accept_s   = push_s && (!full_s || pop_s);
    overflow_d = overflow_q || (push_s && full_s && !pop_s);
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (accept_s) begin
      mem_d[wptr_q] = WriteData[7:0];
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (accept_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !accept_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    busy_d = (state_d != IDLE) || (count_d != CW'(0));
  end

  // State and output registers; reset drives tx high without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= BW'(0);
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= AW'(0);
      rptr_q     <= AW'(0);
      count_q    <= CW'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: table-driven store vectors plus frame-level
// sequences checked bit-time by bit-time against hand-derived 8N1 waveforms.
module tb_mmio_uart_tx;

  localparam int          CPB     = 16;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] TX_ADDR = 32'hFFFF_FFF0;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic        tx;
  logic        tx_busy;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_cmp;
  int n_fail;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TX_ADDR     (TX_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .DataAddr  (DataAddr),
    .WriteData (WriteData),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  exp_count;
    logic        exp_tx;
    logic        exp_busy;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAddr  = addr;
    WriteData = data;
    tick();
    MemWrite  = 1'b0;
    DataAddr  = 32'h0;
    WriteData = 32'h0;
  endtask

  // Samples one frame from bit-time index 'first' to 159; index 0 is the first START sample.
  task automatic check_frame(input logic [7:0] b, input int first, input string name);
    int   bad;
    int   first_bad;
    logic exp_bit;
    logic got_bit;
    bad       = 0;
    first_bad = -1;
    got_bit   = 1'b0;
    exp_bit   = 1'b0;
    for (int i = first; i < 10 * CPB; i++) begin
      tick();
      if (i < CPB)             exp_bit = 1'b0;
      else if (i < 9 * CPB)    exp_bit = b[(i - CPB) / CPB];
      else                     exp_bit = 1'b1;
      if (tx !== exp_bit) begin
        if (bad == 0) begin
          first_bad = i;
          got_bit   = tx;
        end
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d wrong samples, first at %0d got %b expected %b",
               name, bad, first_bad, got_bit, ~got_bit);
    end
  endtask

  vec_t vecs[6];
  logic [7:0] ovf_bytes[10];

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    MemWrite  = 1'b0;
    DataAddr  = 32'h0;
    WriteData = 32'h0;

    vecs[0] = '{1'b1, TX_ADDR + 32'd4,        32'h0000_00FF, 4'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, TX_ADDR - 32'd4,        32'h0000_00FF, 4'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, TX_ADDR ^ 32'h8000_0000, 32'h0000_00FF, 4'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, TX_ADDR,                32'h0000_00FF, 4'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, TX_ADDR,                32'h0000_0055, 4'd1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'h0,                  32'h0000_0000, 4'd0, 1'b0, 1'b1};

    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

    // Reset then idle
    #2 rst = 1'b1;
    #1;
    chk("reset_tx", {31'h0, tx}, 32'd1);
    chk("reset_busy", {31'h0, tx_busy}, 32'd0);
    chk("reset_count", {28'h0, fifo_count}, 32'd0);
    chk("reset_overflow", {31'h0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) bad++;
      end
      chk("idle_100_cycles_bad", bad, 32'd0);
    end

    // Address filter and single push, table-driven
    for (int v = 0; v < 6; v++) begin
      MemWrite  = vecs[v].we;
      DataAddr  = vecs[v].addr;
      WriteData = vecs[v].data;
      tick();
      MemWrite  = 1'b0;
      n_cmp++;
      if (fifo_count !== vecs[v].exp_count || tx !== vecs[v].exp_tx || tx_busy !== vecs[v].exp_busy) begin
        n_fail++;
        $display("FAIL vec%0d: got count=%0d tx=%b busy=%b expected count=%0d tx=%b busy=%b",
                 v, fifo_count, tx, tx_busy, vecs[v].exp_count, vecs[v].exp_tx, vecs[v].exp_busy);
      end
    end
    check_frame(8'h55, 1, "frame_55");
    chk("frame_55_busy_before_end", {31'h0, tx_busy}, 32'd1);
    tick();
    chk("frame_55_busy_after", {31'h0, tx_busy}, 32'd0);
    chk("frame_55_tx_idle", {31'h0, tx}, 32'd1);
    chk("frame_55_count", {28'h0, fifo_count}, 32'd0);
    repeat (5) tick();

    // Back-to-back frames with no idle gap
    store(TX_ADDR, 32'h0000_00A1);
    fork
      begin
        store(TX_ADDR, 32'h1234_56B2);
        store(TX_ADDR, 32'h0000_00C3);
      end
      begin
        check_frame(8'hA1, 0, "b2b_A1");
        check_frame(8'hB2, 0, "b2b_B2");
        check_frame(8'hC3, 0, "b2b_C3");
      end
    join
    tick();
    chk("b2b_busy_after", {31'h0, tx_busy}, 32'd0);
    repeat (5) tick();

    // Overflow: 10 pushes into depth 8, then a push on the STOP-final pop while full
    store(TX_ADDR, {24'h0, ovf_bytes[0]});
    fork
      begin
        for (int k = 1; k < 10; k++) begin
          store(TX_ADDR, {24'h0, ovf_bytes[k]});
          if (k == 8) chk("ovf_not_yet", {31'h0, overflow}, 32'd0);
        end
        chk("ovf_count_sat", {28'h0, fifo_count}, 32'd8);
        chk("ovf_flag", {31'h0, overflow}, 32'd1);
        repeat (151) tick();
        chk("ovf_full_before_pop", {28'h0, fifo_count}, 32'd8);
        store(TX_ADDR, 32'h0000_005C);
        chk("push_on_pop_count", {28'h0, fifo_count}, 32'd8);
      end
      begin
        for (int k = 0; k < 9; k++) check_frame(ovf_bytes[k], 0, $sformatf("ovf_frame%0d", k));
        check_frame(8'h5C, 0, "ovf_frame_5C");
      end
    join
    tick();
    chk("ovf_drained_busy", {31'h0, tx_busy}, 32'd0);
    chk("ovf_sticky", {31'h0, overflow}, 32'd1);

    // Reset during DATA bit 3 of 8'h0F with another byte queued
    store(TX_ADDR, 32'h0000_000F);
    store(TX_ADDR, 32'h0000_00F0);
    repeat (68) tick();
    #2 rst = 1'b1;
    #1;
    chk("midreset_b3_tx", {31'h0, tx}, 32'd1);
    chk("midreset_b3_count", {28'h0, fifo_count}, 32'd0);
    chk("midreset_b3_overflow", {31'h0, overflow}, 32'd0);
    chk("midreset_b3_busy", {31'h0, tx_busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset during DATA bit 4 (tx low) must raise tx before any clock edge
    store(TX_ADDR, 32'h0000_000F);
    repeat (84) tick();
    chk("pre_reset_b4_tx", {31'h0, tx}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midreset_b4_tx_async", {31'h0, tx}, 32'd1);
    tick();
    rst = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0) bad++;
      end
      chk("no_residual_frame_bad", bad, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
